universal_shift_register_n: RTL

- Parametrised universal shift register, WIDTH bits wide.
- Per-cycle modes: hold, logical shift right/left, parallel load, rotate right/left, arithmetic shift right.
- Adds a burst engine: one Start command performs a programmed number of shifts/rotates with Busy/Done handshaking.
- Used as a datapath serialiser/deserialiser and as a shift unit under a controller FSM.

---
 rtl/universal_shift_register_n.sv | 102 ++++++++++
 1 files changed

// File: rtl/universal_shift_register_n.sv
// Universal shift register with per-cycle modes and a burst engine that runs
// a programmed number of shifts/rotates behind a Busy/Done handshake.
module universal_shift_register_n #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] I_par,
    input  logic             MSB_in,
    input  logic             LSB_in,
    input  logic             Start,
    input  logic [CNTW-1:0]  Burst_len,
    output logic [WIDTH-1:0] A_par,
    output logic             MSB_out,
    output logic             LSB_out,
    output logic             Busy,
    output logic             Done,
    output logic [CNTW-1:0]  Remaining
);

    logic [WIDTH-1:0] r_a;
    logic             r_busy;
    logic             r_done;
    logic [CNTW-1:0]  r_rem;
    logic [2:0]       r_bmode;

    logic [2:0]       w_opMode;
    logic [WIDTH-1:0] w_next;
    logic             w_canBurst;

    // A running burst uses its latched mode; otherwise the live Mode input applies.
    always_comb begin
        w_opMode = r_busy ? r_bmode : Mode;
        w_next   = r_a;
        case (w_opMode)
            3'b001:  w_next = {MSB_in, r_a[WIDTH-1:1]};
            3'b010:  w_next = {r_a[WIDTH-2:0], LSB_in};
            3'b011:  w_next = I_par;
            3'b100:  w_next = {r_a[0], r_a[WIDTH-1:1]};
            3'b101:  w_next = {r_a[WIDTH-2:0], r_a[WIDTH-1]};
            3'b110:  w_next = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
            default: w_next = r_a;
        endcase
    end

    always_comb begin
        w_canBurst = 1'b0;
        case (Mode)
            3'b001, 3'b010, 3'b100, 3'b101, 3'b110: w_canBurst = 1'b1;
            default:                                w_canBurst = 1'b0;
        endcase
    end

    // Done is cleared on every edge regardless of En so it stays a single-cycle pulse.
    always_ff @(posedge CLK) begin
        if (Clear) begin
            r_a     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rem   <= '0;
            r_bmode <= 3'b000;
        end else begin
            r_done <= 1'b0;
            if (En) begin
                if (r_busy) begin
                    r_a   <= w_next;
                    r_rem <= r_rem - CNTW'(1);
                    if (r_rem == CNTW'(1)) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end else if (Start && w_canBurst) begin
                    r_bmode <= Mode;
                    r_rem   <= '0;
                    if (Burst_len == '0) begin
                        r_done <= 1'b1;
                    end else if (Burst_len == CNTW'(1)) begin
                        r_a    <= w_next;
                        r_done <= 1'b1;
                    end else begin
                        r_a    <= w_next;
                        r_busy <= 1'b1;
                        r_rem  <= Burst_len - CNTW'(1);
                    end
                end else begin
                    r_a <= w_next;
                end
            end
        end
    end

    assign A_par     = r_a;
    assign MSB_out   = r_a[WIDTH-1];
    assign LSB_out   = r_a[0];
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Remaining = r_rem;

endmodule
